// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1: four-channel round-robin arbiter driving a registered 4:1
// data mux. One output entry; refill and drain may happen in the same cycle.
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_vld,
  output logic [3:0]       in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_sel;
  logic             r_out_vld;
  logic [1:0]       r_ptr;

  logic             w_le;
  logic             w_any;
  logic [1:0]       w_grant;
  logic             w_found;
  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_mux;

  // Output register may accept new data when empty or draining this cycle.
  assign w_le  = !r_out_vld || out_rdy;
  assign w_any = |in_vld;

  // Priority scan starting at the pointer, wrapping modulo 4.
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && in_vld[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Select only the granted channel so undriven losers never reach the register.
  always_comb begin
    case (w_grant)
      2'd0:    w_mux = d0;
      2'd1:    w_mux = d1;
      2'd2:    w_mux = d2;
      default: w_mux = d3;
    endcase
  end

  // One-hot ready toward the winning channel; forced low while in reset.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rdy
      assign in_rdy[gi] = rst && w_le && w_any && (w_grant == 2'(gi));
    end
  endgenerate

  // Output register and pointer: load on a transfer, empty when idle, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_data <= '0;
      r_out_sel  <= 2'd0;
      r_out_vld  <= 1'b0;
      r_ptr      <= 2'd0;
    end else if (w_le) begin
      if (w_any) begin
        r_out_data <= w_mux;
        r_out_sel  <= w_grant;
        r_out_vld  <= 1'b1;
        r_ptr      <= w_grant + 2'd1;
      end else begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_sel  = r_out_sel;
  assign out_vld  = r_out_vld;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb_rr_arb_mux_4_1: directed stimulus with a queue scoreboard; a separate
// monitor pops one expected entry per output transfer.
module tb_rr_arb_mux_4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] in_vld;
  logic [3:0] in_rdy;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_vld;
  logic       out_rdy;

  int tests = 0;
  int fails = 0;

  // expected entry: {data[3:0], sel[1:0]}
  logic [5:0] sb[$];

  rr_arb_mux_4_1 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_sel(out_sel),
    .out_vld(out_vld), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [3:0] dsel(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // Apply one cycle of inputs (called just after a falling edge), check the
  // combinational ready, queue the expected output, advance to the next falling edge.
  task automatic step(input string name, input logic [3:0] vld, input logic rdy,
                      input logic [3:0] exp_rdy);
    in_vld  = vld;
    out_rdy = rdy;
    #1;
    chk(name, {4'b0, in_rdy}, {4'b0, exp_rdy});
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) sb.push_back({dsel(i), 2'(i)});
    @(negedge clk);
  endtask

  task automatic set_d(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e);
    d0 = a; d1 = b; d2 = c; d3 = e;
  endtask

  // Monitor: shortly before each rising edge, an output transfer pops and compares.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL mon_unexpected: got data %0h sel %0d, expected no output", out_data, out_sel);
        end else begin
          e = sb.pop_front();
          chk("mon_data", {4'b0, out_data}, {4'b0, e[5:2]});
          chk("mon_sel", {6'b0, out_sel}, {6'b0, e[1:0]});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_vld = 4'b1111;
    out_rdy = 1'b1;
    set_d(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_rdy", {4'b0, in_rdy}, 8'h00);
    chk("rst_out_vld", {7'b0, out_vld}, 8'h00);
    chk("rst_out_data", {4'b0, out_data}, 8'h00);
    chk("rst_out_sel", {6'b0, out_sel}, 8'h00);
    @(negedge clk);

    // Release reset: first grant channel 0 with data 1.
    rst = 1'b1;
    step("first_grant", 4'b1111, 1'b1, 4'b0001);

    // Round-robin from ptr = 1.
    set_d(4'hA, 4'hB, 4'hC, 4'hD);
    step("rr1", 4'b1111, 1'b1, 4'b0010); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr2", 4'b1111, 1'b1, 4'b0100); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr3", 4'b1111, 1'b1, 4'b1000); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr0", 4'b1111, 1'b1, 4'b0001); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr1", 4'b1111, 1'b1, 4'b0010); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr2", 4'b1111, 1'b1, 4'b0100); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr3", 4'b1111, 1'b1, 4'b1000); chk("rr_vld", {7'b0, out_vld}, 8'h01);
    step("rr0", 4'b1111, 1'b1, 4'b0001); chk("rr_vld", {7'b0, out_vld}, 8'h01);

    // Skip and wrap: grant 1 (ptr -> 2), then only channel 0 valid.
    step("skip_pre", 4'b0010, 1'b1, 4'b0010);
    d0 = 4'd5;
    step("skip_wrap", 4'b0001, 1'b1, 4'b0001);
    step("ptr_after_wrap", 4'b1111, 1'b1, 4'b0010);

    // Back-pressure: load {7, ch2}, then stall three cycles.
    d2 = 4'd7;
    step("bp_load", 4'b0100, 1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step("bp_stall_rdy", 4'b1111, 1'b0, 4'b0000);
      chk("bp_vld", {7'b0, out_vld}, 8'h01);
      chk("bp_data", {4'b0, out_data}, 8'h07);
      chk("bp_sel", {6'b0, out_sel}, 8'h02);
    end
    step("bp_release", 4'b1111, 1'b1, 4'b1000);

    // Idle drain: single transfer from channel 1 then no requests.
    d1 = 4'd9;
    step("drain_load", 4'b0010, 1'b1, 4'b0010);
    step("drain_idle", 4'b0000, 1'b1, 4'b0000);
    chk("drain_vld", {7'b0, out_vld}, 8'h00);
    chk("drain_data", {4'b0, out_data}, 8'h09);
    chk("drain_sel", {6'b0, out_sel}, 8'h01);
    step("drain_idle2", 4'b0000, 1'b1, 4'b0000);
    chk("hold_data", {4'b0, out_data}, 8'h09);
    chk("hold_sel", {6'b0, out_sel}, 8'h01);

    // Reset mid-stream while an entry is stalled; the entry is discarded.
    step("mid_load", 4'b1111, 1'b1, 4'b0100);
    sb.delete();
    rst = 1'b0;
    step("mid_rst_rdy", 4'b1111, 1'b0, 4'b0000);
    chk("mid_rst_vld", {7'b0, out_vld}, 8'h00);
    chk("mid_rst_data", {4'b0, out_data}, 8'h00);
    chk("mid_rst_sel", {6'b0, out_sel}, 8'h00);
    rst = 1'b1;
    step("mid_first_grant", 4'b1111, 1'b1, 4'b0001);
    step("end_idle", 4'b0000, 1'b1, 4'b0000);
    step("end_idle2", 4'b0000, 1'b1, 4'b0000);

    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
